// File: rtl/sample_fifo_if.sv
// Valid/ready handshake bundle for sample_fifo.
// slave = FIFO side, master = producer/consumer side.
interface sample_fifo_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/sample_fifo.sv
// Show-ahead synchronous sample FIFO with sticky overflow flag.
// Define SAMPLE_FIFO_PEAK_EN to add the running-maximum peak output.
module sample_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  sample_fifo_if.slave               bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
`ifdef SAMPLE_FIFO_PEAK_EN
  output logic [DW-1:0]              peak,
`endif
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt_nxt;
  logic          live;
  logic          wr;
  logic          rd;

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;

  // live holds in_ready low until the first edge after reset release
  assign bus.in_ready  = live && !full;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem[rptr];

  assign wr = bus.in_valid && bus.in_ready;
  assign rd = bus.out_valid && bus.out_ready;

  always_comb begin
    cnt_nxt = count;
    unique case ({wr, rd})
      2'b10:   cnt_nxt = count + CW'(1);
      2'b01:   cnt_nxt = count - CW'(1);
      default: cnt_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live  <= 1'b0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      live  <= 1'b1;
      count <= cnt_nxt;
      if (wr)
        wptr <= wptr + AW'(1);
      if (rd)
        rptr <= rptr + AW'(1);
      if (bus.in_valid && full)
        ovf <= 1'b1;
    end
  end

  // Storage is don't-care across reset, so it carries none
  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= bus.in_data;
  end

`ifdef SAMPLE_FIFO_PEAK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      peak <= '0;
    else if (wr && bus.in_data > peak)
      peak <= bus.in_data;
  end
`endif

endmodule

// File: tb/tb_sample_fifo.sv
// Randomized and directed bench for sample_fifo
// against a queue-based reference model.
module tb_sample_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       ovf;
`ifdef SAMPLE_FIFO_PEAK_EN
  logic [DW-1:0] peak;
`endif

  sample_fifo_if #(.DW(DW)) bus ();

  sample_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty),
`ifdef SAMPLE_FIFO_PEAK_EN
    .peak  (peak),
`endif
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q [$];
  logic          live_m;
  logic          ovf_m;
  logic [DW-1:0] peak_m;
  int            errs;
  int            checks;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check();
    int n;
    n = q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("in_ready", 32'(bus.in_ready),
        32'(live_m && n < DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(n > 0));
    chk("out_data", 32'(bus.out_data),
        n > 0 ? 32'(q[0]) : 32'd0);
    chk("ovf", 32'(ovf), 32'(ovf_m));
`ifdef SAMPLE_FIFO_PEAK_EN
    chk("peak", 32'(peak), 32'(peak_m));
`endif
  endtask

  // One clock: model follows the FIFO rules, then compare
  task automatic cycle();
    logic          w;
    logic          r;
    logic [DW-1:0] d;
    w = bus.in_valid && live_m && q.size() < DEPTH;
    r = q.size() > 0 && bus.out_ready;
    d = bus.in_data;
    if (bus.in_valid && q.size() == DEPTH)
      ovf_m = 1'b1;
    @(posedge clk);
    if (r)
      void'(q.pop_front());
    if (w) begin
      q.push_back(d);
      if (d > peak_m)
        peak_m = d;
    end
    live_m = 1'b1;
    @(negedge clk);
    check();
  endtask

  task automatic drive(input logic v,
                       input logic [DW-1:0] d,
                       input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("rst_iready", 32'(bus.in_ready), 32'd0);
    chk("rst_odata", 32'(bus.out_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    q.delete();
    live_m = 1'b0;
    ovf_m  = 1'b0;
    peak_m = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check();
    cycle();
    chk("rdy_after_rst", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic drain(input logic [DW-1:0] exp [$]);
    foreach (exp[i]) begin
      drive(1'b0, '0, 1'b1);
      chk("drain", 32'(bus.out_data), 32'(exp[i]));
      cycle();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] seq [$];
    int bias_in;
    int bias_out;
    errs   = 0;
    checks = 0;
    live_m = 1'b0;
    ovf_m  = 1'b0;
    peak_m = '0;
    drive(1'b0, '0, 1'b0);

    do_reset();

    // Fill to full with reads stalled
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 8'(11 * k), 1'b0);
      cycle();
    end
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_iready", 32'(bus.in_ready), 32'd0);
    chk("fill_odata", 32'(bus.out_data), 32'd11);
    chk("model_size", 32'(q.size()), 32'd8);

    drive(1'b1, 8'd99, 1'b0);
    cycle();
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    seq = {8'd11, 8'd22, 8'd33, 8'd44,
           8'd55, 8'd66, 8'd77, 8'd88};
    drain(seq);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Full plus both strobes: only the read goes
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 8'(k), 1'b0);
      cycle();
    end
    drive(1'b1, 8'd200, 1'b1);
    cycle();
    chk("fullrw_count", 32'(count), 32'd7);
    chk("fullrw_ovf", 32'(ovf), 32'd1);

    // Streaming: one-cycle latency, no bypass
    do_reset();
    drive(1'b1, 8'd11, 1'b1);
    #1;
    chk("no_bypass", 32'(bus.out_valid), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 8'(11 * k), 1'b1);
      cycle();
      chk("stream_data", 32'(bus.out_data), 32'(11 * k));
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
    end
    chk("stream_ovf", 32'(ovf), 32'd0);

    // Pointer wrap
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 8'(11 * k), 1'b0);
      cycle();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1);
      cycle();
    end
    for (int k = 5; k <= 8; k++) begin
      drive(1'b1, 8'(11 * k), 1'b0);
      cycle();
    end
    seq = {8'd55, 8'd66, 8'd77, 8'd88,
           8'd55, 8'd66, 8'd77, 8'd88};
    drain(seq);

    // Mid-operation asynchronous reset
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 8'(k), 1'b0);
      cycle();
    end
    chk("pre_rst_count", 32'(count), 32'd5);
    #2;
    do_reset();

`ifdef SAMPLE_FIFO_PEAK_EN
    seq = {8'd33, 8'd99, 8'd44};
    foreach (seq[i]) begin
      drive(1'b1, seq[i], 1'b0);
      cycle();
      chk("peak_lit", 32'(peak),
          i == 0 ? 32'd33 : 32'd99);
    end
    do_reset();
`endif

    bias_in  = 50;
    bias_out = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        bias_in  = $urandom_range(10, 95);
        bias_out = $urandom_range(10, 95);
      end
      if (i == 1500)
        do_reset();
      drive(32'($urandom_range(0, 99)) < bias_in,
            8'($urandom),
            32'($urandom_range(0, 99)) < bias_out);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
